// File: rtl/program_loader.sv
// program_loader: turns a UART byte stream (32-bit LE word count, then payload words)
// into word-aligned program-memory writes, holding busy until the image is complete.
module program_loader #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int W = ADDR_WIDTH - 2;
  localparam logic [32:0] CAP = 33'd1 << W;
  localparam logic [W:0] ONE = 1;
  typedef enum logic [1:0] {S_HEADER, S_PAYLOAD, S_DONE, S_ERROR} state_t;
  state_t                r_state;
  logic [1:0]            r_bidx;
  logic [W:0]            r_widx;
  logic [31:0]           r_count;
  logic [23:0]           r_buf;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [31:0]           r_wr_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [31:0]           w_word;
  logic                  w_take;
  logic                  w_last_byte;
  logic                  w_last_word;
  // Bytes shift in from the top, so after three bytes r_buf holds lanes 2..0 in place.
  assign w_word      = {rx_data, r_buf};
  assign w_take      = rx_valid && (r_state == S_HEADER || r_state == S_PAYLOAD);
  assign w_last_byte = r_bidx == 2'd3;
  assign w_last_word = 32'(r_widx) + 32'd1 == r_count;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_HEADER;
      r_bidx    <= '0;
      r_widx    <= '0;
      r_count   <= '0;
      r_buf     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else if (start) begin
      r_state <= S_HEADER;
      r_bidx  <= '0;
      r_widx  <= '0;
      r_count <= '0;
      r_wr_en <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_take) begin
        r_buf  <= w_word[31:8];
        r_bidx <= r_bidx + 2'd1;
        if (w_last_byte && r_state == S_HEADER) begin
          r_count <= w_word;
          r_widx  <= '0;
          if (w_word == 32'd0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if ({1'b0, w_word} > CAP) begin
            r_state <= S_ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_state <= S_PAYLOAD;
          end
        end else if (w_last_byte) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= {r_widx[W-1:0], 2'b00};
          r_wr_data <= w_word;
          r_widx    <= r_widx + ONE;
          if (w_last_word) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives a full-size and a 4-bit-address loader with the same byte
// stream and checks both every cycle against a byte-index model, plus literal expectations.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en0, busy0, done0, error0;
  logic [14:0] wr_addr0;
  logic [31:0] wr_data0;
  logic        wr_en1, busy1, done1, error1;
  logic [3:0]  wr_addr1;
  logic [31:0] wr_data1;
  int n_pass = 0;
  int n_total = 0;
  logic [63:0] log0[$];
  logic [63:0] log1[$];

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(15)) dut0 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0), .error(error0)
  );
  program_loader #(.ADDR_WIDTH(4)) dut1 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1), .error(error1)
  );

  function automatic logic [31:0] put(input logic [31:0] a, input int lane, input logic [7:0] b);
    a[8*lane +: 8] = b;
    return a;
  endfunction

  // Model: nb counts bytes accepted since arming; byte 3 closes the header and every
  // later byte with nb%4==3 closes payload word (nb-4)/4.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam longint CAP = (g == 0) ? 64'd8192 : 64'd4;
    int nb;
    logic [31:0] acc, cnt, ad, da, w;
    logic dn, er, we;
    assign w = put(acc, nb % 4, rx_data);
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        nb <= 0; acc <= '0; cnt <= '0; ad <= '0; da <= '0; dn <= 1'b0; er <= 1'b0; we <= 1'b0;
      end else if (start) begin
        nb <= 0; dn <= 1'b0; er <= 1'b0; we <= 1'b0;
      end else begin
        we <= 1'b0;
        if (rx_valid && !dn && !er) begin
          acc <= w;
          nb  <= nb + 1;
          if (nb == 3) begin
            cnt <= w;
            if (w == 0) dn <= 1'b1;
            else if (64'(w) > CAP) er <= 1'b1;
          end else if (nb % 4 == 3) begin
            we <= 1'b1;
            ad <= 32'((nb - 4) / 4 * 4);
            da <= w;
            if (32'((nb - 4) / 4 + 1) == cnt) dn <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
  endtask

  task automatic cmp(input string n, input logic we, input logic [31:0] ad, input logic [31:0] da,
                     input logic bs, input logic dn, input logic er,
                     input logic mwe, input logic [31:0] mad, input logic [31:0] mda,
                     input logic mdn, input logic mer);
    chk({n, " wr_en"}, 64'(we), 64'(mwe));
    chk({n, " wr_addr"}, 64'(ad), 64'(mad));
    chk({n, " wr_data"}, 64'(da), 64'(mda));
    chk({n, " busy"}, 64'(bs), 64'(!(mdn || mer)));
    chk({n, " done"}, 64'(dn), 64'(mdn));
    chk({n, " error"}, 64'(er), 64'(mer));
  endtask

  always @(negedge clk) begin
    cmp("big", wr_en0, 32'(wr_addr0), wr_data0, busy0, done0, error0,
        mdl[0].we, mdl[0].ad, mdl[0].da, mdl[0].dn, mdl[0].er);
    cmp("small", wr_en1, 32'(wr_addr1), wr_data1, busy1, done1, error1,
        mdl[1].we, mdl[1].ad, mdl[1].da, mdl[1].dn, mdl[1].er);
    if (wr_en0) log0.push_back({32'(wr_addr0), wr_data0});
    if (wr_en1) log1.push_back({32'(wr_addr1), wr_data1});
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) idle(int'($urandom_range(0, gap)));
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic arm();
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    log0.delete();
    log1.delete();
  endtask

  task automatic reset_lits(input string n);
    chk({n, " wr_en0"}, 64'(wr_en0), 64'd0);
    chk({n, " wr_addr0"}, 64'(wr_addr0), 64'd0);
    chk({n, " wr_data0"}, 64'(wr_data0), 64'd0);
    chk({n, " busy0"}, 64'(busy0), 64'd1);
    chk({n, " done0"}, 64'(done0), 64'd0);
    chk({n, " error0"}, 64'(error0), 64'd0);
    chk({n, " wr_en1"}, 64'(wr_en1), 64'd0);
    chk({n, " busy1"}, 64'(busy1), 64'd1);
  endtask

  task automatic basic(input string n, input int gap);
    send_word(32'd2, gap);
    send_word(32'h12345678, gap);
    send_word(32'hDEADBEEF, gap);
    idle(3);
    chk({n, " writes"}, 64'(log0.size()), 64'd2);
    chk({n, " w0"}, log0[0], {32'h0, 32'h12345678});
    chk({n, " w1"}, log0[1], {32'h4, 32'hDEADBEEF});
    chk({n, " small w1"}, log1[1], {32'h4, 32'hDEADBEEF});
    chk({n, " done"}, 64'(done0), 64'd1);
    chk({n, " busy"}, 64'(busy0), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    @(negedge clk);
    reset_lits("por");
    reset = 1'b0;
    basic("basic", 0);
    arm();
    basic("gapped", 5);
    arm();
    send_word(32'd0, 0);
    send_word(32'hDDCCBBAA, 0);
    idle(3);
    chk("zero writes", 64'(log0.size() + log1.size()), 64'd0);
    chk("zero done", 64'(done0), 64'd1);
    chk("zero busy", 64'(busy0), 64'd0);
    arm();
    send_word(32'd4, 0);
    for (int i = 1; i <= 4; i++) send_word(32'(i), 0);
    idle(3);
    chk("cap4 writes", 64'(log1.size()), 64'd4);
    chk("cap4 first", log1[0], {32'h0, 32'd1});
    chk("cap4 last", log1[3], {32'hC, 32'd4});
    chk("cap4 done", 64'(done1), 64'd1);
    arm();
    send_word(32'd5, 0);
    idle(1);
    chk("cap5 error", 64'(error1), 64'd1);
    chk("cap5 busy", 64'(busy1), 64'd0);
    for (int i = 1; i <= 5; i++) send_word(32'(i), 1);
    idle(3);
    chk("cap5 no writes", 64'(log1.size()), 64'd0);
    chk("cap5 done", 64'(done1), 64'd0);
    chk("cap5 big writes", 64'(log0.size()), 64'd5);
    chk("cap5 big done", 64'(done0), 64'd1);
    arm();
    send_word(32'd3, 0);
    send_word(32'hCAFEF00D, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h03;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    chk("abort busy", 64'(busy0), 64'd1);
    send_word(32'd1, 0);
    send_word(32'h44332211, 0);
    idle(3);
    chk("abort writes", 64'(log0.size()), 64'd2);
    chk("abort w0", log0[0], {32'h0, 32'hCAFEF00D});
    chk("abort fresh", log0[1], {32'h0, 32'h44332211});
    chk("abort done", 64'(done0), 64'd1);
    arm();
    send_word(32'd2, 0);
    send_word(32'h11111111, 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 reset_lits("async");
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    log0.delete();
    log1.delete();
    basic("post-reset", 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
